// File: rtl/alu_decode_stage.sv
// ID stage: decodes an RV32 ALU/branch subset into one-hot ALU enables and
// registers it in the ID/EX pipeline register. Optional trap: ALU_DECODE_ILLEGAL_TRAP_EN.
module alu_decode_stage #(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            add_en,
  output logic            sub_en,
  output logic            xor_en,
  output logic            or_en,
  output logic            and_en,
  output logic            eq_en,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm,
  output logic            use_imm,
  output logic            reg_write,
  output logic            is_branch,
  output logic            branch_ne,
  output logic [XLEN-1:0] pc_out,
  output logic            illegal
);

  // Enable vector bit order: {add, sub, xor, or, and, eq}
  localparam logic [5:0] EN_ADD = 6'b100000, EN_SUB = 6'b010000, EN_XOR = 6'b001000,
                         EN_OR  = 6'b000100, EN_AND = 6'b000010, EN_EQ  = 6'b000001;

  typedef struct packed {
    logic [5:0]      en;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            use_imm;
    logic            rw;
    logic            br;
    logic            ne;
    logic            ill;
    logic [XLEN-1:0] pc;
  } pay_t;

  pay_t dec, p_d, p_q;
  logic valid_d, valid_q;
  logic halt_d, halt_q;
  logic dec_rw, dec_ill, accept;

  wire [6:0] opcode = instr[6:0];
  wire [2:0] f3     = instr[14:12];
  wire [6:0] f7     = instr[31:25];
  wire [4:0] rd_f   = instr[11:7];

  always_comb begin
    dec         = '0;
    dec_rw      = 1'b0;
    dec_ill     = 1'b0;
    dec.rs1     = instr[19:15];
    dec.rs2     = instr[24:20];
    dec.pc      = pc;
    case (opcode)
      7'b0110011: begin
        dec_rw = 1'b1;
        case ({f7, f3})
          {7'h00, 3'b000}: dec.en = EN_ADD;
          {7'h20, 3'b000}: dec.en = EN_SUB;
          {7'h00, 3'b100}: dec.en = EN_XOR;
          {7'h00, 3'b110}: dec.en = EN_OR;
          {7'h00, 3'b111}: dec.en = EN_AND;
          default: begin dec_rw = 1'b0; dec_ill = 1'b1; end
        endcase
      end
      7'b0010011: begin
        dec_rw      = 1'b1;
        dec.use_imm = 1'b1;
        dec.imm     = {{(XLEN-12){instr[31]}}, instr[31:20]};
        case (f3)
          3'b000:  dec.en = EN_ADD;
          3'b100:  dec.en = EN_XOR;
          3'b110:  dec.en = EN_OR;
          3'b111:  dec.en = EN_AND;
          default: begin dec_rw = 1'b0; dec_ill = 1'b1; dec.use_imm = 1'b0; dec.imm = '0; end
        endcase
      end
      7'b1100011: begin
        if (f3 == 3'b000 || f3 == 3'b001) begin
          dec.en  = EN_EQ;
          dec.br  = 1'b1;
          dec.ne  = f3[0];
          dec.imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        end else begin
          dec_ill = 1'b1;
        end
      end
      default: dec_ill = 1'b1;
    endcase
    // A write to x0 is no write at all, and rd is only meaningful when writing.
    dec.rw = dec_rw && (rd_f != 5'd0);
    dec.rd = dec.rw ? rd_f : 5'd0;
`ifdef ALU_DECODE_ILLEGAL_TRAP_EN
    dec.ill = dec_ill;
`else
    dec.ill = 1'b0;
`endif
  end

  assign in_ready = (!valid_q || out_ready) && !halt_q;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    valid_d = valid_q;
    p_d     = p_q;
    halt_d  = halt_q;
    if (flush) begin
      valid_d = 1'b0;
      p_d.en  = '0;
      p_d.rw  = 1'b0;
      p_d.ill = 1'b0;
      p_d.br  = 1'b0;
      halt_d  = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      p_d     = dec;
`ifdef ALU_DECODE_ILLEGAL_TRAP_EN
      halt_d  = dec.ill;
`endif
    end else if (valid_q && out_ready) begin
      // Consumed with nothing behind it: enables must read 0 while invalid.
      valid_d = 1'b0;
      p_d.en  = '0;
      p_d.rw  = 1'b0;
      p_d.ill = 1'b0;
      p_d.br  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      halt_q  <= 1'b0;
      p_q     <= '0;
      p_q.pc  <= RESET_PC;
    end else begin
      valid_q <= valid_d;
      halt_q  <= halt_d;
      p_q     <= p_d;
    end
  end

  assign out_valid = valid_q;
  assign {add_en, sub_en, xor_en, or_en, and_en, eq_en} = p_q.en;
  assign rs1       = p_q.rs1;
  assign rs2       = p_q.rs2;
  assign rd        = p_q.rd;
  assign imm       = p_q.imm;
  assign use_imm   = p_q.use_imm;
  assign reg_write = p_q.rw;
  assign is_branch = p_q.br;
  assign branch_ne = p_q.ne;
  assign pc_out    = p_q.pc;
  assign illegal   = p_q.ill;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Self-checking bench for alu_decode_stage: directed scenarios plus a randomized
// run against an instruction-level reference model.
module tb_alu_decode_stage;

  localparam logic [31:0] RPC = 32'h8000_0000;

  logic clk = 1'b0, reset = 1'b1;
  logic in_valid = 1'b0, in_ready, flush = 1'b0, out_valid, out_ready = 1'b0;
  logic [31:0] instr = '0, pc = '0, imm, pc_out;
  logic add_en, sub_en, xor_en, or_en, and_en, eq_en;
  logic [4:0] rs1, rs2, rd;
  logic use_imm, reg_write, is_branch, branch_ne, illegal;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  alu_decode_stage #(.XLEN(32), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .add_en(add_en), .sub_en(sub_en), .xor_en(xor_en), .or_en(or_en), .and_en(and_en),
    .eq_en(eq_en), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .use_imm(use_imm),
    .reg_write(reg_write), .is_branch(is_branch), .branch_ne(branch_ne),
    .pc_out(pc_out), .illegal(illegal)
  );

  typedef struct packed {
    logic        v;
    logic [5:0]  en;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        ui, rw, br, ne, ill;
    logic [31:0] pc;
  } exp_t;

  wire [5:0] en_o = {add_en, sub_en, xor_en, or_en, and_en, eq_en};

`ifdef ALU_DECODE_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  // Reference decode by instruction mnemonic (mask/match pairs from the ISA).
  function automatic exp_t ref_dec(input logic [31:0] i, input logic [31:0] p);
    exp_t e;
    logic signed [11:0] iimm;
    logic signed [12:0] bimm;
    logic w;
    e = '0; e.v = 1'b1; e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.pc = p; w = 1'b0;
    iimm = i[31:20];
    bimm = {i[31], i[7], i[30:25], i[11:8], 1'b0};
    if      ((i & 32'hFE00707F) == 32'h00000033) begin e.en = 6'd32; w = 1; end // ADD
    else if ((i & 32'hFE00707F) == 32'h40000033) begin e.en = 6'd16; w = 1; end // SUB
    else if ((i & 32'hFE00707F) == 32'h00004033) begin e.en = 6'd8;  w = 1; end // XOR
    else if ((i & 32'hFE00707F) == 32'h00006033) begin e.en = 6'd4;  w = 1; end // OR
    else if ((i & 32'hFE00707F) == 32'h00007033) begin e.en = 6'd2;  w = 1; end // AND
    else if ((i & 32'h0000707F) == 32'h00000013) begin e.en = 6'd32; w = 1; e.ui = 1; e.imm = 32'(iimm); end
    else if ((i & 32'h0000707F) == 32'h00004013) begin e.en = 6'd8;  w = 1; e.ui = 1; e.imm = 32'(iimm); end
    else if ((i & 32'h0000707F) == 32'h00006013) begin e.en = 6'd4;  w = 1; e.ui = 1; e.imm = 32'(iimm); end
    else if ((i & 32'h0000707F) == 32'h00007013) begin e.en = 6'd2;  w = 1; e.ui = 1; e.imm = 32'(iimm); end
    else if ((i & 32'h0000707F) == 32'h00000063) begin e.en = 6'd1; e.br = 1; e.imm = 32'(bimm); end
    else if ((i & 32'h0000707F) == 32'h00001063) begin e.en = 6'd1; e.br = 1; e.ne = 1; e.imm = 32'(bimm); end
    else e.ill = TRAP;
    e.rw = w && (i[11:7] != 0);
    e.rd = e.rw ? i[11:7] : 5'd0;
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] r;
    logic [2:0] f3;
    r = $urandom;
    case ($urandom_range(0, 4))
      0: begin
        f3 = 3'($urandom_range(0, 3));
        f3 = (f3 == 0) ? 3'b000 : (f3 == 1) ? 3'b100 : (f3 == 2) ? 3'b110 : 3'b111;
        return {($urandom_range(0, 3) == 0 && f3 == 0) ? 7'h20 : 7'h00, r[24:15], f3, r[11:7], 7'b0110011};
      end
      1: return {r[31:7], 7'b0010011};
      2: return {r[31:15], 2'b00, r[12], r[11:7], 7'b1100011};
      3: return {r[31:7], 7'b1100011};
      default: return r;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; instr = 32'h002081B3; out_ready = 1'b1;
    tick(); tick();
    in_valid = 1'b0; reset = 1'b0; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if ({en_o, reg_write, use_imm, is_branch, branch_ne, illegal} !== 11'd0) begin errors++;
      $display("FAIL reset_ctrl got %b exp 0", {en_o, reg_write, use_imm, is_branch, branch_ne, illegal}); end
    checks++; if ({rs1, rs2, rd, imm} !== 47'd0) begin errors++; $display("FAIL reset_fields got %h exp 0", {rs1, rs2, rd, imm}); end
    checks++; if (pc_out !== RPC) begin errors++; $display("FAIL reset_pc got %h exp %h", pc_out, RPC); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_add();
    out_ready = 1'b1; in_valid = 1'b1; instr = 32'h002081B3; pc = 32'h100;
    tick(); in_valid = 1'b0; #1;
    checks++; if ({out_valid, en_o} !== 7'b1_100000) begin errors++; $display("FAIL add_en got %b exp 1100000", {out_valid, en_o}); end
    checks++; if ({rs1, rs2, rd, reg_write, use_imm} !== {5'd1, 5'd2, 5'd3, 2'b10}) begin errors++;
      $display("FAIL add_fields got %h exp %h", {rs1, rs2, rd, reg_write, use_imm}, {5'd1, 5'd2, 5'd3, 2'b10}); end
    checks++; if (pc_out !== 32'h100) begin errors++; $display("FAIL add_pc got %h exp 100", pc_out); end
    tick();
    checks++; if ({out_valid, en_o, reg_write} !== 8'd0) begin errors++; $display("FAIL add_drain got %b exp 0", {out_valid, en_o, reg_write}); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1; in_valid = 1'b1; instr = 32'h402081B3;
    tick(); instr = 32'hFFF00293; #1;
    checks++; if ({out_valid, en_o, rd, in_ready} !== {1'b1, 6'b010000, 5'd3, 1'b1}) begin errors++;
      $display("FAIL b2b_sub got %h exp %h", {out_valid, en_o, rd, in_ready}, {1'b1, 6'b010000, 5'd3, 1'b1}); end
    tick(); in_valid = 1'b0; #1;
    checks++; if ({out_valid, en_o, use_imm, reg_write, rd} !== {1'b1, 6'b100000, 2'b11, 5'd5}) begin errors++;
      $display("FAIL b2b_addi got %h exp %h", {out_valid, en_o, use_imm, reg_write, rd}, {1'b1, 6'b100000, 2'b11, 5'd5}); end
    checks++; if (imm !== 32'hFFFFFFFF) begin errors++; $display("FAIL b2b_imm got %h exp ffffffff", imm); end
    tick();
  endtask

  task automatic test_branch();
    out_ready = 1'b1; in_valid = 1'b1; instr = 32'h00208463;
    tick(); in_valid = 1'b0; #1;
    checks++; if ({out_valid, en_o, is_branch, branch_ne, reg_write, rd} !== {1'b1, 6'b000001, 3'b100, 5'd0}) begin errors++;
      $display("FAIL beq_ctrl got %h exp %h", {out_valid, en_o, is_branch, branch_ne, reg_write, rd}, {1'b1, 6'b000001, 3'b100, 5'd0}); end
    checks++; if (imm !== 32'd8) begin errors++; $display("FAIL beq_imm got %h exp 8", imm); end
    tick();
  endtask

  task automatic test_stall();
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h002081B3;
    tick();
    for (int k = 0; k < 3; k++) begin
      instr = 32'h0020E2B3; #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d] got %b exp 0", k, in_ready); end
      checks++; if ({out_valid, en_o, rd} !== {1'b1, 6'b100000, 5'd3}) begin errors++;
        $display("FAIL stall_hold[%0d] got %h exp %h", k, {out_valid, en_o, rd}, {1'b1, 6'b100000, 5'd3}); end
      tick();
    end
    instr = 32'h0020C233; out_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release got %b exp 1", in_ready); end
    tick(); in_valid = 1'b0; #1;
    checks++; if ({out_valid, en_o, rd} !== {1'b1, 6'b001000, 5'd4}) begin errors++;
      $display("FAIL stall_next got %h exp %h", {out_valid, en_o, rd}, {1'b1, 6'b001000, 5'd4}); end
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b1; in_valid = 1'b1; instr = 32'h002081B3; flush = 1'b1;
    tick(); flush = 1'b0; in_valid = 1'b0; #1;
    checks++; if ({out_valid, en_o, reg_write} !== 8'd0) begin errors++; $display("FAIL flush_accept got %b exp 0", {out_valid, en_o, reg_write}); end
    tick();
    checks++; if ({out_valid, en_o} !== 7'd0) begin errors++; $display("FAIL flush_never got %b exp 0", {out_valid, en_o}); end
    out_ready = 1'b0; in_valid = 1'b1;
    tick(); in_valid = 1'b0; flush = 1'b1;
    tick(); flush = 1'b0; #1;
    checks++; if ({out_valid, en_o, reg_write} !== 8'd0) begin errors++; $display("FAIL flush_held got %b exp 0", {out_valid, en_o, reg_write}); end
    out_ready = 1'b1;
  endtask

  task automatic test_illegal();
    out_ready = 1'b1; in_valid = 1'b1; instr = 32'h0000007F;
    tick(); in_valid = 1'b0; #1;
`ifdef ALU_DECODE_ILLEGAL_TRAP_EN
    checks++; if ({out_valid, illegal, en_o, reg_write, in_ready} !== {2'b11, 8'd0}) begin errors++;
      $display("FAIL ill_trap got %b exp 1100000000", {out_valid, illegal, en_o, reg_write, in_ready}); end
    in_valid = 1'b1; instr = 32'h002081B3;
    tick(); tick(); #1;
    checks++; if ({out_valid, in_ready} !== 2'b00) begin errors++; $display("FAIL ill_halt got %b exp 00", {out_valid, in_ready}); end
    in_valid = 1'b0; flush = 1'b1;
    tick(); flush = 1'b0; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ill_unhalt got %b exp 1", in_ready); end
`else
    checks++; if ({out_valid, illegal, en_o, reg_write, is_branch, in_ready} !== {1'b1, 9'd0, 1'b1}) begin errors++;
      $display("FAIL ill_nop got %b exp 10000000001", {out_valid, illegal, en_o, reg_write, is_branch, in_ready}); end
    tick();
`endif
  endtask

  task automatic test_random();
    exp_t m, o;
    logic mh, erdy;
    reset = 1'b1; tick(); reset = 1'b0;
    m = '0; mh = 1'b0;
    for (int n = 0; n < 600; n++) begin
      in_valid = ($urandom_range(0, 3) != 0); out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 15) == 0); instr = gen_instr(); pc = $urandom;
      #1;
      erdy = (!m.v || out_ready) && !mh;
      o = '{out_valid, en_o, rs1, rs2, rd, imm, use_imm, reg_write, is_branch, branch_ne, illegal, pc_out};
      checks++; if (in_ready !== erdy) begin errors++; $display("FAIL rnd_ready[%0d] got %b exp %b", n, in_ready, erdy); end
      checks++;
      if (m.v ? (o !== m) : ({o.v, o.en, o.rw, o.ill} !== {m.v, m.en, m.rw, m.ill})) begin errors++;
        $display("FAIL rnd_out[%0d] got %h exp %h", n, o, m); end
      if (flush) begin
        m.v = 0; m.en = 0; m.rw = 0; m.ill = 0; mh = 0;
      end else if (in_valid && erdy) begin
        m = ref_dec(instr, pc); mh = m.ill;
      end else if (out_ready) begin
        m.v = 0; m.en = 0; m.rw = 0; m.ill = 0;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_branch();
    test_stall();
    test_flush();
    test_illegal();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout reached before summary");
    $fatal(1, "timeout");
  end

endmodule
